// File: rtl/const_div_seq_if.sv
// Operand/result handshake bundle for const_div_seq; RW follows the divisor width.
// Latency: none (wiring only). Backpressure: carries in_ready/out_ready between producer, divider and consumer.
// The divider takes the slave modport; the operand producer / result consumer side takes master.
interface const_div_seq_if #(
    parameter int WIDTH   = 32,
    parameter int DIVISOR = 5
);
    localparam int RW = $clog2(DIVISOR);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic [RW-1:0]    out_r;
    logic             busy;

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_q, out_r, busy
    );

    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_q, out_r, busy
    );
endinterface

// File: rtl/const_div_seq.sv
// Sequential divide by constant DIVISOR, CHUNK dividend bits per cycle, MS-first; CONST_DIV_SEQ_ROUND_EN rounds q half up.
// Latency: result valid NSTEP+1 cycles after the accept cycle; one result per NSTEP+1 cycles when out_ready stays high.
// Backpressure: result held in DONE while out_ready is low (in_ready low); a new operand is taken in the DONE release cycle.
module const_div_seq #(
    parameter int WIDTH   = 32,
    parameter int DIVISOR = 5,
    parameter int CHUNK   = 4
) (
    input logic            clk,
    input logic            rst_n,
    const_div_seq_if.slave bus
);
    localparam int RW    = $clog2(DIVISOR);
    localparam int NSTEP = WIDTH / CHUNK;
    localparam int TW    = RW + CHUNK;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $error("const_div_seq: CHUNK must be >= 1");
        end else if (WIDTH % CHUNK != 0) begin : g_bad_width
            $error("const_div_seq: WIDTH must be a multiple of CHUNK");
        end
        if (DIVISOR < 2) begin : g_bad_divisor
            $error("const_div_seq: DIVISOR must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] quot_q;
    logic [RW-1:0]    rem_q;
    logic [SW-1:0]    step_q;

    logic             acc_rdy;
    logic             accept;
    logic             last_step;
    logic [TW-1:0]    t;
    logic [CHUNK-1:0] qd;
    logic [RW-1:0]    rem_d;
    logic [WIDTH-1:0] quot_shift;
    logic [WIDTH-1:0] quot_fin;

    // rem < DIVISOR keeps t below DIVISOR*2^CHUNK, so the digit always fits CHUNK bits
    assign t          = {rem_q, shift_q[WIDTH-1 -: CHUNK]};
    assign qd         = CHUNK'(t / TW'(DIVISOR));
    assign rem_d      = RW'(t % TW'(DIVISOR));
    assign quot_shift = WIDTH'({quot_q, qd});
    assign last_step  = (step_q == SW'(NSTEP - 1));

`ifdef CONST_DIV_SEQ_ROUND_EN
    logic round_up;
    // 2*rem >= DIVISOR; floor(max/DIVISOR)+1 cannot wrap since DIVISOR >= 2
    assign round_up = ({1'b0, rem_d, 1'b0} >= (RW + 2)'(DIVISOR));
    assign quot_fin = quot_shift + WIDTH'(round_up);
`else
    assign quot_fin = quot_shift;
`endif

    always_comb begin
        state_d = state_q;
        acc_rdy = 1'b0;
        case (state_q)
            IDLE: begin
                acc_rdy = 1'b1;
                if (bus.in_valid) state_d = RUN;
            end
            RUN: begin
                if (last_step) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    acc_rdy = 1'b1;
                    state_d = bus.in_valid ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = bus.in_valid & acc_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            step_q  <= '0;
        end else if (accept) begin
            shift_q <= bus.in_x;
            quot_q  <= '0;
            rem_q   <= '0;
            step_q  <= '0;
        end else if (state_q == RUN) begin
            shift_q <= shift_q << CHUNK;
            quot_q  <= last_step ? quot_fin : quot_shift;
            rem_q   <= rem_d;
            step_q  <= step_q + 1'b1;
        end
    end

    assign bus.in_ready  = acc_rdy;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN);
    assign bus.out_q     = quot_q;
    assign bus.out_r     = rem_q;
endmodule

// File: tb/tb_const_div_seq.sv
// Bench for const_div_seq: directed literal cases plus random traffic on a 32/5/4 and a 24/7/3 instance.
module tb_const_div_seq;
    localparam int WA = 32, DA = 5, CA = 4;
    localparam int WB = 24, DB = 7, CB = 3;
    localparam int N_RAND = 2500;
`ifdef CONST_DIV_SEQ_ROUND_EN
    localparam bit ROUND = 1'b1;
    localparam logic [63:0] Q_FE = 64'h33333333, Q_8 = 64'd2, Q_13 = 64'd3;
`else
    localparam bit ROUND = 1'b0;
    localparam logic [63:0] Q_FE = 64'h33333332, Q_8 = 64'd1, Q_13 = 64'd2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic rst_b_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   done_b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    const_div_seq_if #(.WIDTH(WA), .DIVISOR(DA)) ia ();
    const_div_seq_if #(.WIDTH(WB), .DIVISOR(DB)) ib ();

    const_div_seq #(.WIDTH(WA), .DIVISOR(DA), .CHUNK(CA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    const_div_seq #(.WIDTH(WB), .DIVISOR(DB), .CHUNK(CB)) dut_b (.clk(clk), .rst_n(rst_b_n), .bus(ib.slave));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: plain floor division, optional round-half-up on the quotient
    function automatic logic [63:0] ref_q(input logic [63:0] x, input logic [63:0] d);
        logic [63:0] q;
        q = x / d;
        if (ROUND && (2 * (x % d) >= d)) q = q + 1;
        return q;
    endfunction

    function automatic logic [63:0] ref_r(input logic [63:0] x, input logic [63:0] d);
        return x % d;
    endfunction

    function automatic logic [31:0] rand_x(input int w);
        logic [31:0] v;
        case ($urandom % 8)
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'($urandom % 64);
            default: v = $urandom;
        endcase
        return (w >= 32) ? v : (v & ((32'd1 << w) - 32'd1));
    endfunction

    // Scoreboards
    logic [63:0] qa_q[$], qa_r[$], qb_q[$], qb_r[$];
    int acc_a = 0, out_a = 0, acc_b = 0, out_b = 0;
    bit hold_a = 1'b0, hold_b = 1'b0;
    logic [63:0] hq_a, hr_a, hq_b, hr_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            acc_a -= qa_q.size();
            qa_q.delete();
            qa_r.delete();
            hold_a = 1'b0;
        end else begin
            if (hold_a) begin
                chk("a_hold_vld", 64'(ia.out_valid), 64'd1);
                chk("a_hold_q", 64'(ia.out_q), hq_a);
                chk("a_hold_r", 64'(ia.out_r), hr_a);
            end
            if (ia.busy) chk("a_rdy_in_run", 64'(ia.in_ready), 64'd0);
            if (ia.out_valid && ia.out_ready) begin
                if (qa_q.size() == 0) fail_now("a_spurious_result");
                else begin
                    chk("a_q", 64'(ia.out_q), qa_q.pop_front());
                    chk("a_r", 64'(ia.out_r), qa_r.pop_front());
                    out_a++;
                end
            end
            if (ia.in_valid && ia.in_ready) begin
                qa_q.push_back(ref_q(64'(ia.in_x), 64'(DA)));
                qa_r.push_back(ref_r(64'(ia.in_x), 64'(DA)));
                acc_a++;
            end
            hold_a = ia.out_valid && !ia.out_ready;
            hq_a = 64'(ia.out_q);
            hr_a = 64'(ia.out_r);
        end
        if (!rst_b_n) begin
            acc_b -= qb_q.size();
            qb_q.delete();
            qb_r.delete();
            hold_b = 1'b0;
        end else begin
            if (hold_b) begin
                chk("b_hold_vld", 64'(ib.out_valid), 64'd1);
                chk("b_hold_q", 64'(ib.out_q), hq_b);
                chk("b_hold_r", 64'(ib.out_r), hr_b);
            end
            if (ib.busy) chk("b_rdy_in_run", 64'(ib.in_ready), 64'd0);
            if (ib.out_valid && ib.out_ready) begin
                if (qb_q.size() == 0) fail_now("b_spurious_result");
                else begin
                    chk("b_q", 64'(ib.out_q), qb_q.pop_front());
                    chk("b_r", 64'(ib.out_r), qb_r.pop_front());
                    out_b++;
                end
            end
            if (ib.in_valid && ib.in_ready) begin
                qb_q.push_back(ref_q(64'(ib.in_x), 64'(DB)));
                qb_r.push_back(ref_r(64'(ib.in_x), 64'(DB)));
                acc_b++;
            end
            hold_b = ib.out_valid && !ib.out_ready;
            hq_b = 64'(ib.out_q);
            hr_b = 64'(ib.out_r);
        end
    end

    // Offer x until taken; returns the cycle index of the handshake cycle
    task automatic send_a(input logic [31:0] x, output int acc_cyc);
        bit got;
        got = 1'b0;
        acc_cyc = -1;
        ia.in_valid = 1'b1;
        ia.in_x = x;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ia.in_ready) begin
                got = 1'b1;
                acc_cyc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        ia.in_valid = 1'b0;
        if (!got) fail_now("a_send_timeout");
    endtask

    task automatic wait_out_a(output int vld_cyc, output int busy_cnt);
        bit got;
        got = 1'b0;
        vld_cyc = -1;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ia.busy) busy_cnt++;
            if (ia.out_valid) begin
                got = 1'b1;
                vld_cyc = cyc;
                break;
            end
        end
        if (!got) fail_now("a_result_timeout");
    endtask

    task automatic direct_a(input string name, input logic [31:0] x,
                            input logic [63:0] eq, input logic [63:0] er);
        int c0, c1, bc;
        send_a(x, c0);
        wait_out_a(c1, bc);
        chk({name, "_q"}, 64'(ia.out_q), eq);
        chk({name, "_r"}, 64'(ia.out_r), er);
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (qa_q.size() == 0 && !ia.busy && !ia.out_valid) break;
        end
        chk("a_pending", 64'(qa_q.size()), 64'd0);
        chk("a_count", 64'(out_a), 64'(acc_a));
    endtask

    // Instance B: random traffic only
    initial begin
        int sent;
        bit took;
        rst_b_n = 1'b0;
        ib.in_valid = 1'b0;
        ib.in_x = '0;
        ib.out_ready = 1'b0;
        #23 rst_b_n = 1'b1;
        sent = 0;
        took = 1'b0;
        while (sent < N_RAND) begin
            @(posedge clk);
            #1;
            if (took) ib.in_valid = 1'b0;
            ib.out_ready = ($urandom % 4) != 0;
            if (!ib.in_valid && ($urandom % 3) != 0) begin
                ib.in_valid = 1'b1;
                ib.in_x = WB'(rand_x(WB));
            end
            @(negedge clk);
            took = ib.in_valid && ib.in_ready;
            if (took) sent++;
        end
        @(posedge clk);
        #1;
        ib.in_valid = 1'b0;
        ib.out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (qb_q.size() == 0 && !ib.busy && !ib.out_valid) break;
        end
        chk("b_pending", 64'(qb_q.size()), 64'd0);
        chk("b_count", 64'(out_b), 64'(acc_b));
        done_b = 1'b1;
    end

    // Instance A: directed cases, then random traffic
    initial begin
        int c0, c1, bc, sent;
        bit took;
        rst_n = 1'b0;
        ia.in_valid = 1'b0;
        ia.in_x = '0;
        ia.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(ia.in_ready), 64'd1);
        chk("rst_out_valid", 64'(ia.out_valid), 64'd0);
        chk("rst_busy", 64'(ia.busy), 64'd0);
        chk("rst_out_q", 64'(ia.out_q), 64'd0);
        chk("rst_out_r", 64'(ia.out_r), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency and busy length on x=100
        send_a(32'd100, c0);
        wait_out_a(c1, bc);
        chk("lat_100", 64'(c1 - c0), 64'd9);
        chk("busy_100", 64'(bc), 64'd8);
        chk("q_100", 64'(ia.out_q), 64'd20);
        chk("r_100", 64'(ia.out_r), 64'd0);
        @(posedge clk);
        #1;

        direct_a("max", 32'hFFFF_FFFF, 64'h33333333, 64'd0);
        direct_a("maxm1", 32'hFFFF_FFFE, Q_FE, 64'd4);
        direct_a("seven", 32'd7, 64'd1, 64'd2);
        direct_a("eight", 32'd8, Q_8, 64'd3);
        direct_a("zero", 32'd0, 64'd0, 64'd0);

        // Backpressure: hold result 5 cycles with a new operand waiting
        ia.out_ready = 1'b0;
        send_a(32'd13, c0);
        wait_out_a(c1, bc);
        @(posedge clk);
        #1;
        ia.in_valid = 1'b1;
        ia.in_x = 32'd21;
        repeat (5) begin
            @(negedge clk);
            chk("bp_vld", 64'(ia.out_valid), 64'd1);
            chk("bp_in_ready", 64'(ia.in_ready), 64'd0);
            chk("bp_q", 64'(ia.out_q), Q_13);
            chk("bp_r", 64'(ia.out_r), 64'd3);
        end
        @(posedge clk);
        #1;
        ia.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_accept", 64'(ia.in_ready), 64'd1);
        @(posedge clk);
        #1;
        ia.in_valid = 1'b0;
        chk("bp_next_busy", 64'(ia.busy), 64'd1);
        wait_out_a(c1, bc);
        chk("bp_next_q", 64'(ia.out_q), 64'd4);
        chk("bp_next_r", 64'(ia.out_r), 64'd1);
        @(posedge clk);
        #1;

        // Asynchronous reset at step 4 of a run
        send_a(32'd1234, c0);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(ia.out_valid), 64'd0);
        chk("arst_in_ready", 64'(ia.in_ready), 64'd1);
        chk("arst_busy", 64'(ia.busy), 64'd0);
        chk("arst_out_q", 64'(ia.out_q), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        direct_a("after_rst", 32'd55, 64'd11, 64'd0);

        // Random traffic with random stalls on both sides
        sent = 0;
        took = 1'b0;
        while (sent < N_RAND) begin
            @(posedge clk);
            #1;
            if (took) ia.in_valid = 1'b0;
            ia.out_ready = ($urandom % 4) != 0;
            if (!ia.in_valid && ($urandom % 3) != 0) begin
                ia.in_valid = 1'b1;
                ia.in_x = rand_x(WA);
            end
            @(negedge clk);
            took = ia.in_valid && ia.in_ready;
            if (took) sent++;
        end
        @(posedge clk);
        #1;
        ia.in_valid = 1'b0;
        ia.out_ready = 1'b1;
        drain_a();

        for (int i = 0; i < 20000 && !done_b; i++) @(negedge clk);
        if (!done_b) fail_now("b_finish_timeout");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete (checks=%0d failures=%0d)", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
